// File: rtl/umi_ram_arb.sv
// N-port UMI device RAM: runtime-selectable arbiter in front of one RAMDEPTH x DW array,
// byte-granular sub-row access and a one-entry response slot per port.

module umi_ram_arb_slot #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load_i,
  input  logic          ready_i,
  input  logic [CW-1:0] cmd_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW-1:0] src_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [CW-1:0] cmd_o,
  output logic [AW-1:0] dst_o,
  output logic [AW-1:0] src_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q, valid_d;
  logic [CW-1:0] cmd_q;
  logic [AW-1:0] dst_q, src_q;
  logic [DW-1:0] data_q;

  // A load while draining replaces the outgoing entry, so there is no bubble.
  always_comb begin
    valid_d = valid_q;
    if (load_i)       valid_d = 1'b1;
    else if (ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        cmd_q  <= cmd_i;
        dst_q  <= dst_i;
        src_q  <= src_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign cmd_o   = cmd_q;
  assign dst_o   = dst_q;
  assign src_o   = src_q;
  assign data_o  = data_q;
endmodule

module umi_ram_arb #(
  parameter int N        = 4,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 256,
  parameter int RAMDEPTH = 512,
  parameter int CTRLW    = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [1:0]           mode,
  input  logic [CTRLW-1:0]     sram_ctrl,
  input  logic [N-1:0]         udev_req_valid,
  output logic [N-1:0]         udev_req_ready,
  input  logic [N-1:0][CW-1:0] udev_req_cmd,
  input  logic [N-1:0][AW-1:0] udev_req_dstaddr,
  input  logic [N-1:0][AW-1:0] udev_req_srcaddr,
  input  logic [N-1:0][DW-1:0] udev_req_data,
  output logic [N-1:0]         udev_resp_valid,
  input  logic [N-1:0]         udev_resp_ready,
  output logic [N-1:0][CW-1:0] udev_resp_cmd,
  output logic [N-1:0][AW-1:0] udev_resp_dstaddr,
  output logic [N-1:0][AW-1:0] udev_resp_srcaddr,
  output logic [N-1:0][DW-1:0] udev_resp_data
);
  localparam int NBY = DW / 8;
  localparam int OB  = $clog2(NBY);
  localparam int RB  = $clog2(RAMDEPTH);
  localparam int PW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [4:0] REQ_POSTED = 5'h05;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } umi_pkt_t;

  function automatic logic needs_resp(input logic [4:0] op);
    return (op == REQ_READ) || (op == REQ_WRITE);
  endfunction

  logic [N-1:0]   elig, load;
  logic [PW-1:0]  ptr_q, ptr_d, gidx;
  logic           gvld, we;
  umi_pkt_t       req, resp;
  logic [4:0]     op;
  logic [2:0]     size;
  logic [7:0]     len;
  logic [15:0]    nb;
  logic [OB-1:0]  off;
  logic [RB-1:0]  row;
  logic [NBY-1:0] bmask, be;
  logic [DW-1:0]  wsh, rsh, rdata;
  logic [DW-1:0]  mem [RAMDEPTH];

  // A full slot only blocks requests that would need it.
  always_comb begin
    for (int i = 0; i < N; i++)
      elig[i] = udev_req_valid[i] &
                (~needs_resp(udev_req_cmd[i][4:0]) | ~udev_resp_valid[i] | udev_resp_ready[i]);
  end

  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    if (mode[1]) begin
      for (int k = 1; k <= N; k++) begin
        if (!gvld && elig[PW'((int'(ptr_q) + k) % N)]) begin
          gvld = 1'b1;
          gidx = PW'((int'(ptr_q) + k) % N);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!gvld && elig[i]) begin
          gvld = 1'b1;
          gidx = PW'(i);
        end
      end
    end
    gvld = gvld & nreset;
  end

  always_comb begin
    udev_req_ready = '0;
    if (gvld) udev_req_ready[gidx] = 1'b1;
  end

  assign ptr_d = gvld ? gidx : ptr_q;

  always_ff @(posedge clk) begin
    if (!nreset) ptr_q <= PW'(N - 1);
    else         ptr_q <= ptr_d;
  end

  always_comb begin
    req.cmd  = udev_req_cmd[gidx];
    req.dst  = udev_req_dstaddr[gidx];
    req.src  = udev_req_srcaddr[gidx];
    req.data = udev_req_data[gidx];
  end

  assign op   = req.cmd[4:0];
  assign size = req.cmd[7:5];
  assign len  = req.cmd[15:8];
  assign nb   = (16'(len) + 16'd1) << size;
  assign off  = req.dst[OB-1:0];
  assign row  = req.dst[OB+RB-1:OB];

  // Bytes past the row end fall off the shifts: unwritten on writes, zero on reads.
  always_comb begin
    for (int k = 0; k < NBY; k++) bmask[k] = nb > 16'(k);
  end

  assign be  = bmask << off;
  assign wsh = req.data << {off, 3'b000};
  assign rsh = mem[row] >> {off, 3'b000};

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NBY; k++)
      if (bmask[k]) rdata[k*8 +: 8] = rsh[k*8 +: 8];
  end

  assign we = gvld && (op == REQ_WRITE || op == REQ_POSTED);

  always_ff @(posedge clk) begin
    if (we)
      for (int j = 0; j < NBY; j++)
        if (be[j]) mem[row][j*8 +: 8] <= wsh[j*8 +: 8];
  end

  always_comb begin
    resp.cmd  = {req.cmd[CW-1:5], (op == REQ_READ) ? RESP_READ : RESP_WRITE};
    resp.dst  = req.src;
    resp.src  = req.dst;
    resp.data = (op == REQ_READ) ? rdata : '0;
    load      = '0;
    if (gvld && needs_resp(op)) load[gidx] = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    umi_ram_arb_slot #(.CW(CW), .AW(AW), .DW(DW)) u_slot (
      .clk     (clk),
      .nreset  (nreset),
      .load_i  (load[i]),
      .ready_i (udev_resp_ready[i]),
      .cmd_i   (resp.cmd),
      .dst_i   (resp.dst),
      .src_i   (resp.src),
      .data_i  (resp.data),
      .valid_o (udev_resp_valid[i]),
      .cmd_o   (udev_resp_cmd[i]),
      .dst_o   (udev_resp_dstaddr[i]),
      .src_o   (udev_resp_srcaddr[i]),
      .data_o  (udev_resp_data[i])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{sram_ctrl, mode[0], req.dst[AW-1:OB+RB]};
endmodule

// File: tb/tb_umi_ram_arb.sv
// Bench for umi_ram_arb: directed steps plus random traffic, checked every cycle
// against a byte-array RAM model and per-port expected response slots.

module tb_umi_ram_arb;
  localparam int N = 4, CW = 32, AW = 64, DW = 256, RAMDEPTH = 512, CTRLW = 8, NBY = 32;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic [1:0]           mode;
  logic [CTRLW-1:0]     sram_ctrl;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][CW-1:0] req_cmd, resp_cmd;
  logic [N-1:0][AW-1:0] req_dst, req_src, resp_dst, resp_src;
  logic [N-1:0][DW-1:0] req_data, resp_data;

  always #5 clk = ~clk;

  umi_ram_arb #(.N(N), .CW(CW), .AW(AW), .DW(DW), .RAMDEPTH(RAMDEPTH), .CTRLW(CTRLW)) dut (
    .clk(clk), .nreset(nreset), .mode(mode), .sram_ctrl(sram_ctrl),
    .udev_req_valid(req_valid), .udev_req_ready(req_ready), .udev_req_cmd(req_cmd),
    .udev_req_dstaddr(req_dst), .udev_req_srcaddr(req_src), .udev_req_data(req_data),
    .udev_resp_valid(resp_valid), .udev_resp_ready(resp_ready), .udev_resp_cmd(resp_cmd),
    .udev_resp_dstaddr(resp_dst), .udev_resp_srcaddr(resp_src), .udev_resp_data(resp_data)
  );

  int vectors = 0, miscompares = 0;
  bit sticky = 0;

  // Reference model: RAM as a flat byte array, one expected response per port.
  logic [7:0]           mb [RAMDEPTH*NBY];
  logic [N-1:0]         m_vld;
  logic [N-1:0][CW-1:0] m_cmd;
  logic [N-1:0][AW-1:0] m_dst, m_src;
  logic [N-1:0][DW-1:0] m_data;
  int                   m_ptr;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic needs_resp(input logic [4:0] op);
    return op == 5'h01 || op == 5'h03;
  endfunction

  function automatic int model_grant();
    logic [N-1:0] el;
    if (!nreset) return -1;
    for (int i = 0; i < N; i++)
      el[i] = req_valid[i] && (!needs_resp(req_cmd[i][4:0]) || !m_vld[i] || resp_ready[i]);
    if (mode[1]) begin
      for (int k = 1; k <= N; k++) if (el[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end else begin
      for (int i = 0; i < N; i++) if (el[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = '0; m_cmd = '0; m_dst = '0; m_src = '0; m_data = '0;
    m_ptr = N - 1;
  endtask

  task automatic model_update(input int g);
    logic [4:0]    op;
    int            nb, off, row;
    logic [DW-1:0] rd;
    if (!nreset) begin model_reset(); return; end
    for (int i = 0; i < N; i++) if (resp_ready[i]) m_vld[i] = 1'b0;
    if (g < 0) return;
    m_ptr = g;
    op  = req_cmd[g][4:0];
    nb  = (int'(req_cmd[g][15:8]) + 1) << int'(req_cmd[g][7:5]);
    off = int'(req_dst[g][4:0]);
    row = int'(req_dst[g][13:5]);
    rd  = '0;
    for (int k = 0; k < nb && off + k < NBY; k++) begin
      if (op == 5'h01) rd[k*8 +: 8] = mb[row*NBY + off + k];
      if (op == 5'h03 || op == 5'h05) mb[row*NBY + off + k] = req_data[g][k*8 +: 8];
    end
    if (needs_resp(op)) begin
      m_vld[g]  = 1'b1;
      m_cmd[g]  = {req_cmd[g][CW-1:5], (op == 5'h01) ? 5'h02 : 5'h04};
      m_dst[g]  = req_src[g];
      m_src[g]  = req_dst[g];
      m_data[g] = (op == 5'h01) ? rd : '0;
    end
  endtask

  // Called with inputs set just after a negedge; returns at the following negedge.
  task automatic cycle();
    int           g;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, m_vld);
    for (int i = 0; i < N; i++)
      chk($sformatf("resp_fields%0d", i), {resp_cmd[i], resp_dst[i], resp_src[i], resp_data[i]},
          {m_cmd[i], m_dst[i], m_src[i], m_data[i]});
    @(posedge clk);
    @(negedge clk);
    model_update(g);
    if (g >= 0 && !sticky) req_valid[g] = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic set_req(input int p, input logic [4:0] op, input int sz, input int ln,
                         input logic [AW-1:0] dst, input logic [AW-1:0] src,
                         input logic [DW-1:0] data);
    req_cmd[p]  = {16'($urandom), 8'(ln), 3'(sz), op};
    req_dst[p]  = dst;
    req_src[p]  = src;
    req_data[p] = data;
  endtask

  task automatic send(input int p, input logic [4:0] op, input int sz, input int ln,
                      input logic [AW-1:0] dst, input logic [AW-1:0] src,
                      input logic [DW-1:0] data);
    set_req(p, op, sz, ln, dst, src, data);
    req_valid[p] = 1'b1;
    for (int c = 0; c < 20 && req_valid[p]; c++) cycle();
    chk("send_accept", req_valid[p], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp;
    logic [4:0]    ops [6];
    ops = '{5'h01, 5'h03, 5'h05, 5'h07, 5'h01, 5'h03};
    nreset = 1'b0; mode = 2'b10; sram_ctrl = '0;
    req_valid = '0; req_cmd = '0; req_dst = '0; req_src = '0; req_data = '0;
    resp_ready = '1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // Held reset with a pending (droppable) request: no ready, empty slots.
    set_req(0, 5'h00, 0, 0, 64'h0, 64'h0, '0);
    req_valid[0] = 1'b1;
    cycle();
    nreset = 1'b1;
    cycle();

    for (int r = 0; r < 8; r++) send(r % N, 5'h03, 5, 0, 64'(r * 32), 64'h100, rnd256());

    send(0, 5'h03, 3, 0, 64'h40, 64'h8000, 256'h1122334455667788);
    chk("wr_resp", {resp_valid[0], resp_cmd[0][4:0]}, {1'b1, 5'h04});
    send(0, 5'h01, 3, 0, 64'h40, 64'h9000, '0);
    chk("rd_op", resp_cmd[0][4:0], 5'h02);
    chk("rd_data", resp_data[0], 256'h1122334455667788);
    chk("rd_dst", resp_dst[0], 64'h9000);
    chk("rd_src", resp_src[0], 64'h40);

    send(0, 5'h03, 5, 0, 64'h0, 64'h0, '1);
    send(1, 5'h03, 0, 1, 64'h5, 64'h0, 256'hBEEF);
    send(0, 5'h01, 5, 0, 64'h0, 64'h100, '0);
    exp = '1; exp[47:40] = 8'hEF; exp[55:48] = 8'hBE;
    chk("subrow_rd", resp_data[0], exp);

    send(2, 5'h03, 3, 0, 64'h1C, 64'h0, 256'h1122334455667788);
    send(2, 5'h01, 3, 0, 64'h1C, 64'h200, '0);
    chk("overflow_rd", resp_data[2], 256'h55667788);

    // Three responses held, then reset flushes them but not the RAM.
    resp_ready = 4'b1000;
    for (int p = 0; p < 3; p++) set_req(p, 5'h01, 3, 0, 64'(32 * (p + 3)), 64'h300, '0);
    req_valid = 4'b0111;
    for (int c = 0; c < 10 && req_valid != 0; c++) cycle();
    chk("pending3", resp_valid, 4'b0111);
    nreset = 1'b0;
    cycle();
    chk("rst_flush", resp_valid, 4'b0000);
    nreset = 1'b1; resp_ready = '1;
    send(3, 5'h01, 3, 0, 64'h40, 64'h400, '0);
    chk("ram_kept", resp_data[3], 256'h1122334455667788);

    sticky = 1;
    for (int p = 0; p < N; p++) set_req(p, 5'h01, 2, 1, 64'(32 * p), 64'h500, '0);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_grant", req_ready, 4'b0001 << (c % 4));
      cycle();
    end
    mode = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1 chk("fp_grant", req_ready, 4'b0001);
      cycle();
    end
    sticky = 0; req_valid = '0; mode = 2'b10;
    cycle();

    // Port 2 backpressured: it must block only itself.
    resp_ready = 4'b1011;
    send(2, 5'h01, 3, 0, 64'h60, 64'h600, '0);
    sticky = 1;
    for (int p = 0; p < 3; p++) set_req(p, 5'h01, 3, 0, 64'(32 * p), 64'h700, '0);
    req_valid = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("blk_ready2", req_ready[2], 1'b0);
      chk("blk_valid2", resp_valid[2], 1'b1);
      chk("blk_others", req_ready[1:0] != 2'b00, 1'b1);
      cycle();
    end
    sticky = 0;
    set_req(2, 5'h05, 3, 0, 64'hA0, 64'h0, 256'hCAFE);
    req_valid = 4'b0100;
    for (int c = 0; c < 10 && req_valid[2]; c++) cycle();
    chk("posted_accept", req_valid[2], 1'b0);
    resp_ready = '1;
    repeat (2) cycle();

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++)
        if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
          set_req(p, ops[$urandom_range(0, 5)], $urandom_range(0, 5), $urandom_range(0, 7),
                  {32'($urandom), 24'h0, 8'($urandom)}, {32'($urandom), 32'($urandom)}, rnd256());
          req_valid[p] = 1'b1;
        end
      resp_ready = 4'($urandom);
      sram_ctrl  = 8'($urandom);
      if (c % 50 == 0) mode = 2'($urandom);
      cycle();
    end
    req_valid = '0; resp_ready = '1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
